// File: rtl/tempsens_cal_lut_loader.sv
// Calibration-LUT serial loader: fetches every table word and shifts it to the sensor on cal_clk/cal_dat.
// Optional CRC-8 of the shifted bit stream when TEMPSENS_CAL_CRC_EN is defined.
module tempsens_cal_lut_loader #(
    parameter int N_VDAC      = 7,
    parameter int N_LUT       = 7,
    parameter int HALF_PERIOD = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    output logic [N_VDAC-1:0] rd_addr,
    input  logic [N_LUT-1:0]  rd_data,
    input  logic              cal_ena_req,
    output logic              cal_clk,
    output logic              cal_dat,
    output logic              cal_ena,
    output logic              busy,
`ifdef TEMPSENS_CAL_CRC_EN
    output logic [7:0]        crc,
`endif
    output logic              done
);

    localparam int HPW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam int BCW = (N_LUT > 1) ? $clog2(N_LUT) : 1;
    localparam logic [HPW-1:0] HP_LAST  = HPW'(HALF_PERIOD - 1);
    localparam logic [BCW-1:0] BIT_LAST = BCW'(N_LUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_SHIFT_LO,
        S_SHIFT_HI,
        S_FIN
    } state_t;

    state_t             state_q, state_d;
    logic [N_VDAC-1:0]  idx_q, idx_d;
    logic [N_LUT-1:0]   sr_q, sr_d;
    logic [N_LUT-1:0]   sr_shifted;
    logic [BCW-1:0]     bit_q, bit_d;
    logic [HPW-1:0]     hp_q, hp_d;
    logic               lut_valid_q, lut_valid_d;
    logic               cal_clk_q, cal_clk_d;
    logic               cal_dat_q, cal_dat_d;
    logic               cal_ena_q, cal_ena_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    assign sr_shifted = sr_q << 1;

    // NOTE: every signal gets its default before the case, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        sr_d        = sr_q;
        bit_d       = bit_q;
        hp_d        = hp_q;
        lut_valid_d = lut_valid_q;
        cal_dat_d   = cal_dat_q;

        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    state_d     = S_FETCH;
                    idx_d       = '1;
                    lut_valid_d = 1'b0;
                end
            end
            S_FETCH: state_d = S_LOAD;
            S_LOAD: begin
                sr_d      = rd_data;
                bit_d     = BIT_LAST;
                hp_d      = '0;
                cal_dat_d = rd_data[N_LUT-1];
                state_d   = S_SHIFT_LO;
            end
            S_SHIFT_LO: begin
                if (hp_q == HP_LAST) begin
                    hp_d    = '0;
                    state_d = S_SHIFT_HI;
                end else begin
                    hp_d = hp_q + HPW'(1);
                end
            end
            S_SHIFT_HI: begin
                if (hp_q == HP_LAST) begin
                    hp_d = '0;
                    if (bit_q != '0) begin
                        sr_d      = sr_shifted;
                        bit_d     = bit_q - BCW'(1);
                        cal_dat_d = sr_shifted[N_LUT-1];
                        state_d   = S_SHIFT_LO;
                    end else if (idx_q != '0) begin
                        idx_d   = idx_q - N_VDAC'(1);
                        state_d = S_FETCH;
                    end else begin
                        lut_valid_d = 1'b1;
                        state_d     = S_FIN;
                    end
                end else begin
                    hp_d = hp_q + HPW'(1);
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Abort drops a partial load; the sensor LUT contents are no longer trustworthy.
        if (abort && (state_q inside {S_FETCH, S_LOAD, S_SHIFT_LO, S_SHIFT_HI})) begin
            state_d     = S_IDLE;
            lut_valid_d = 1'b0;
        end

        busy_d    = state_d inside {S_FETCH, S_LOAD, S_SHIFT_LO, S_SHIFT_HI};
        done_d    = (state_d == S_FIN);
        cal_clk_d = (state_d == S_SHIFT_HI);
        if (state_d == S_IDLE) begin
            cal_dat_d = 1'b0;
        end
        cal_ena_d = lut_valid_d & cal_ena_req & ~busy_d;
    end

    // NOTE: clocked state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            idx_q       <= '1;
            sr_q        <= '0;
            bit_q       <= '0;
            hp_q        <= '0;
            lut_valid_q <= 1'b0;
            cal_clk_q   <= 1'b0;
            cal_dat_q   <= 1'b0;
            cal_ena_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            sr_q        <= sr_d;
            bit_q       <= bit_d;
            hp_q        <= hp_d;
            lut_valid_q <= lut_valid_d;
            cal_clk_q   <= cal_clk_d;
            cal_dat_q   <= cal_dat_d;
            cal_ena_q   <= cal_ena_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign rd_addr = idx_q;
    assign cal_clk = cal_clk_q;
    assign cal_dat = cal_dat_q;
    assign cal_ena = cal_ena_q;
    assign busy    = busy_q;
    assign done    = done_q;

`ifdef TEMPSENS_CAL_CRC_EN
    logic [7:0] crc_q, crc_d;

    // Each bit is folded in on the cycle cal_clk rises, i.e. the last SHIFT_LO cycle.
    always_comb begin
        crc_d = crc_q;
        if (state_q == S_IDLE && start && !abort) begin
            crc_d = 8'h00;
        end else if (state_q == S_SHIFT_LO && hp_q == HP_LAST) begin
            crc_d = {crc_q[6:0], 1'b0} ^ ({8{crc_q[7] ^ cal_dat_q}} & 8'h07);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            crc_q <= 8'h00;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc = crc_q;
`endif

endmodule

// File: tb/tb_tempsens_cal_lut_loader.sv
// Bench for tempsens_cal_lut_loader: default instance plus a HALF_PERIOD=1 instance, receiver-side model.
module tb_tempsens_cal_lut_loader;

    localparam int NV     = 7;
    localparam int NL     = 7;
    localparam int ENT    = 1 << NV;
    localparam int NBITS  = ENT * NL;
    localparam int BUSY_A = ENT * (2 + 2 * NL * 4);
    localparam int BUSY_B = ENT * (2 + 2 * NL * 1);

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic          start_a = 1'b0, abort_a = 1'b0, req_a = 1'b0;
    logic [NV-1:0] rd_addr_a;
    logic [NL-1:0] rd_data_a;
    logic          cal_clk_a, cal_dat_a, cal_ena_a, busy_a, done_a;

    logic          start_b = 1'b0, abort_b = 1'b0, req_b = 1'b0;
    logic [NV-1:0] rd_addr_b;
    logic [NL-1:0] rd_data_b;
    logic          cal_clk_b, cal_dat_b, cal_ena_b, busy_b, done_b;

`ifdef TEMPSENS_CAL_CRC_EN
    logic [7:0] crc_a, crc_b;
`endif

    logic [NL-1:0] tbl_a [ENT];

    always @(posedge clk) rd_data_a <= tbl_a[rd_addr_a];
    assign rd_data_b = 7'h55;

    tempsens_cal_lut_loader dut_a (
        .clk(clk), .reset(reset), .start(start_a), .abort(abort_a),
        .rd_addr(rd_addr_a), .rd_data(rd_data_a), .cal_ena_req(req_a),
        .cal_clk(cal_clk_a), .cal_dat(cal_dat_a), .cal_ena(cal_ena_a), .busy(busy_a),
`ifdef TEMPSENS_CAL_CRC_EN
        .crc(crc_a),
`endif
        .done(done_a)
    );

    tempsens_cal_lut_loader #(.HALF_PERIOD(1)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .abort(abort_b),
        .rd_addr(rd_addr_b), .rd_data(rd_data_b), .cal_ena_req(req_b),
        .cal_clk(cal_clk_b), .cal_dat(cal_dat_b), .cal_ena(cal_ena_b), .busy(busy_b),
`ifdef TEMPSENS_CAL_CRC_EN
        .crc(crc_b),
`endif
        .done(done_b)
    );

    int   checks = 0;
    int   errors = 0;
    bit   bits_a[$];
    bit   bits_b[$];
    int   rises_a = 0, rises_b = 0;
    logic prev_a = 1'b0, prev_b = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock; outputs are sampled on the falling edge and every cal_clk rise is captured.
    task automatic tick();
        @(negedge clk);
        if (cal_clk_a === 1'b1 && prev_a === 1'b0) begin
            bits_a.push_back(cal_dat_a);
            rises_a++;
        end
        prev_a = cal_clk_a;
        if (cal_clk_b === 1'b1 && prev_b === 1'b0) begin
            bits_b.push_back(cal_dat_b);
            rises_b++;
        end
        prev_b = cal_clk_b;
    endtask

    // Bitwise CRC-8 (poly 0x07, init 0) over entries high-to-low, each MSB first.
    function automatic logic [7:0] crc_model_a();
        logic [7:0] c;
        logic       b;
        c = 8'h00;
        for (int e = ENT - 1; e >= 0; e--) begin
            for (int j = NL - 1; j >= 0; j--) begin
                b = tbl_a[e][j];
                c = {c[6:0], 1'b0} ^ (((c[7] ^ b) == 1'b1) ? 8'h07 : 8'h00);
            end
        end
        return c;
    endfunction

    task automatic full_load_a(input string tag, input int mid_start);
        int               busy_cnt;
        bit               ena_seen;
        int               bad;
        logic [NBITS-1:0] chain;
        bits_a.delete();
        rises_a  = 0;
        start_a  = 1'b1;
        tick();
        start_a  = 1'b0;
`ifdef TEMPSENS_CAL_CRC_EN
        check({tag, "_crc_cleared"}, 32'(crc_a), 32'h0);
`endif
        busy_cnt = 0;
        ena_seen = 1'b0;
        while (busy_a === 1'b1 && busy_cnt < 20000) begin
            busy_cnt++;
            if (cal_ena_a !== 1'b0) ena_seen = 1'b1;
            start_a = (busy_cnt == mid_start);
            tick();
        end
        start_a = 1'b0;
        check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(BUSY_A));
        check({tag, "_done_pulse"}, 32'(done_a), 32'h1);
        check({tag, "_ena_low_in_load"}, 32'(ena_seen), 32'h0);
        check({tag, "_rises"}, 32'(rises_a), 32'(NBITS));
        // Receiver: one long shift register, new bits enter at the LSB.
        chain = '0;
        foreach (bits_a[k]) chain = {chain[NBITS-2:0], bits_a[k]};
        bad = 0;
        for (int i = 0; i < ENT; i++) begin
            if (chain[i*NL +: NL] !== tbl_a[i]) bad++;
        end
        check({tag, "_rx_lut_bad_entries"}, 32'(bad), 32'h0);
`ifdef TEMPSENS_CAL_CRC_EN
        check({tag, "_crc"}, 32'(crc_a), 32'(crc_model_a()));
`endif
        tick();
        check({tag, "_done_one_cycle"}, 32'(done_a), 32'h0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int         n;
        int         bad;
        bit         r;
        bit         done_seen, ena_seen, busy_seen;
        logic [6:0] v;
        bit         seq [3];

        // Reset held two cycles.
        reset = 1'b1;
        tick();
        tick();
        check("rst_cal_clk", 32'(cal_clk_a), 32'h0);
        check("rst_cal_dat", 32'(cal_dat_a), 32'h0);
        check("rst_cal_ena", 32'(cal_ena_a), 32'h0);
        check("rst_busy", 32'(busy_a), 32'h0);
        check("rst_done", 32'(done_a), 32'h0);
        check("rst_rd_addr", 32'(rd_addr_a), 32'h7f);
        check("rst_b_rd_addr", 32'(rd_addr_b), 32'h7f);
        check("rst_b_cal_ena", 32'(cal_ena_b), 32'h0);
`ifdef TEMPSENS_CAL_CRC_EN
        check("rst_crc", 32'(crc_a), 32'h0);
`endif
        reset = 1'b0;
        tick();
        check("idle_busy", 32'(busy_a), 32'h0);

        // Identity table.
        for (int i = 0; i < ENT; i++) tbl_a[i] = NL'(i);
        full_load_a("ident", -1);
        if (bits_a.size() >= NL) begin
            v = '0;
            for (int k = 0; k < NL; k++) v = {v[5:0], bits_a[k]};
            check("ident_first7", 32'(v), 32'h7f);
            v = '0;
            for (int k = bits_a.size() - NL; k < bits_a.size(); k++) v = {v[5:0], bits_a[k]};
            check("ident_last7", 32'(v), 32'h00);
        end

        // cal_ena follows cal_ena_req one cycle later once the LUT is valid.
        seq[0] = 1'b1;
        seq[1] = 1'b0;
        seq[2] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            req_a = seq[k];
            tick();
            check("ena_follow_dir", 32'(cal_ena_a), 32'(seq[k]));
        end
        for (int k = 0; k < 20; k++) begin
            r     = 1'($urandom_range(0, 1));
            req_a = r;
            tick();
            check("ena_follow_rand", 32'(cal_ena_a), 32'(r));
        end

        // Random table, start re-asserted mid-load (ignored), enable requested throughout.
        for (int i = 0; i < ENT; i++) tbl_a[i] = NL'($urandom);
        req_a = 1'b1;
        tick();
        full_load_a("rand", int'($urandom_range(100, 7000)));
        check("rand_ena_after_load", 32'(cal_ena_a), 32'h1);

        // Abort after the 300th rising edge.
        bits_a.delete();
        rises_a = 0;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        n = 0;
        while (rises_a < 300 && n < 10000) begin
            tick();
            n++;
        end
        check("abort_reached_300", 32'(rises_a), 32'd300);
        abort_a = 1'b1;
        tick();
        abort_a = 1'b0;
        check("abort_busy", 32'(busy_a), 32'h0);
        check("abort_cal_clk", 32'(cal_clk_a), 32'h0);
        check("abort_cal_dat", 32'(cal_dat_a), 32'h0);
        check("abort_done", 32'(done_a), 32'h0);
        done_seen = 1'b0;
        ena_seen  = 1'b0;
        busy_seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (done_a !== 1'b0) done_seen = 1'b1;
            if (cal_ena_a !== 1'b0) ena_seen = 1'b1;
            if (busy_a !== 1'b0) busy_seen = 1'b1;
        end
        check("abort_no_done", 32'(done_seen), 32'h0);
        check("abort_ena_stays0", 32'(ena_seen), 32'h0);
        check("abort_stays_idle", 32'(busy_seen), 32'h0);
        check("abort_no_more_rises", 32'(rises_a), 32'd300);

        // start and abort together in IDLE: abort wins.
        start_a = 1'b1;
        abort_a = 1'b1;
        tick();
        start_a = 1'b0;
        abort_a = 1'b0;
        check("start_abort_busy", 32'(busy_a), 32'h0);
        tick();
        check("start_abort_busy2", 32'(busy_a), 32'h0);
        check("start_abort_rises", 32'(rises_a), 32'd300);

        // Reset in the middle of a load.
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        repeat ($urandom_range(50, 3000)) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_cal_clk", 32'(cal_clk_a), 32'h0);
        check("midrst_cal_dat", 32'(cal_dat_a), 32'h0);
        check("midrst_cal_ena", 32'(cal_ena_a), 32'h0);
        check("midrst_busy", 32'(busy_a), 32'h0);
        check("midrst_done", 32'(done_a), 32'h0);
        check("midrst_rd_addr", 32'(rd_addr_a), 32'h7f);
`ifdef TEMPSENS_CAL_CRC_EN
        check("midrst_crc", 32'(crc_a), 32'h0);
`endif
        tick();
        tick();
        check("midrst_lut_invalid", 32'(cal_ena_a), 32'h0);
        req_a = 1'b0;

        // HALF_PERIOD=1 instance with a constant 0x55 table.
        bits_b.delete();
        rises_b = 0;
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        n = 0;
        while (busy_b === 1'b1 && n < 20000) begin
            n++;
            tick();
        end
        check("hp1_busy_cycles", 32'(n), 32'(BUSY_B));
        check("hp1_done", 32'(done_b), 32'h1);
        check("hp1_rises", 32'(rises_b), 32'(NBITS));
        bad = 0;
        foreach (bits_b[k]) begin
            if (bits_b[k] != ((k % NL) % 2 == 0)) bad++;
        end
        check("hp1_pattern_bad_bits", 32'(bad), 32'h0);
        tick();

`ifdef TEMPSENS_CAL_CRC_EN
        for (int i = 0; i < ENT; i++) tbl_a[i] = '0;
        full_load_a("zero", -1);
        check("zero_crc_is_00", 32'(crc_a), 32'h00);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
